// File: rtl/iterative_divider_if.sv
// Handshake/data bundle for iterative_divider.
// The master drives operands and controls; the slave (the divider) returns the result and status.
interface iterative_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]         div_op;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               flush;
  logic [2*WIDTH-1:0] result;
  logic               result_valid;
  logic               busy;
  logic               done;

  modport master (
    output div_op, dividend, divisor, flush,
    input  result, result_valid, busy, done
  );

  modport slave (
    input  div_op, dividend, divisor, flush,
    output result, result_valid, busy, done
  );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider, signed/unsigned, one quotient bit per cycle; result = {quo, rem}.
// Define DIVIDER_FAST_ZERO_EN to finish divide-by-zero two cycles after the start.
module iterative_divider #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  iterative_divider_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StPrep, StIter, StFix} state_e;

  state_e             state_q;
  logic               signed_q;
  logic               q_neg_q;
  logic               r_neg_q;
  logic               div_zero_q;
  logic               busy_q;
  logic               done_q;
  logic               result_valid_q;
  logic [WIDTH-1:0]   dvd_raw_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH:0]     rem_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] result_q;

  logic               start;
  logic               dvd_neg;
  logic               dvs_neg;
  logic [WIDTH-1:0]   dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    start     = (bus.div_op == 2'b01) || (bus.div_op == 2'b10);
    // dvs_q holds the raw divisor only during PREP; afterwards it holds the magnitude
    dvd_neg   = signed_q & dvd_raw_q[WIDTH-1];
    dvs_neg   = signed_q & dvs_q[WIDTH-1];
    dvd_abs   = dvd_neg ? -dvd_raw_q : dvd_raw_q;
    dvs_abs   = dvs_neg ? -dvs_q : dvs_q;
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, dvs_q};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    if (div_zero_q) begin
      quo_fix = '1;
      rem_fix = dvd_raw_q;
    end else begin
      quo_fix = q_neg_q ? -quo_q : quo_q;
      rem_fix = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      signed_q       <= 1'b0;
      q_neg_q        <= 1'b0;
      r_neg_q        <= 1'b0;
      div_zero_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b1;
      result_valid_q <= 1'b0;
      dvd_raw_q      <= '0;
      dvs_q          <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
    end else begin
      result_valid_q <= 1'b0;
      if (bus.flush) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              dvd_raw_q <= bus.dividend;
              dvs_q     <= bus.divisor;
              signed_q  <= bus.div_op[1];
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              state_q   <= StPrep;
            end
          end
          StPrep: begin
            quo_q      <= dvd_abs;
            rem_q      <= '0;
            dvs_q      <= dvs_abs;
            q_neg_q    <= dvd_neg ^ dvs_neg;
            r_neg_q    <= dvd_neg;
            div_zero_q <= (dvs_q == '0);
            cnt_q      <= CntW'(WIDTH);
`ifdef DIVIDER_FAST_ZERO_EN
            state_q    <= (dvs_q == '0) ? StFix : StIter;
`else
            state_q    <= StIter;
`endif
          end
          StIter: begin
            rem_q <= rem_ge ? rem_sub : rem_shift;
            quo_q <= {quo_q[WIDTH-2:0], rem_ge};
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              state_q <= StFix;
            end
          end
          StFix: begin
            result_q       <= {quo_fix, rem_fix};
            result_valid_q <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b1;
            state_q        <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider at WIDTH=32 and WIDTH=8.
// Directed cases use literal expectations; random sweeps use a plain-arithmetic reference model.
module tb_iterative_divider;

`ifdef DIVIDER_FAST_ZERO_EN
  localparam bit FastZero = 1'b1;
`else
  localparam bit FastZero = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  iterative_divider_if #(.WIDTH(32)) b32 ();
  iterative_divider_if #(.WIDTH(8))  b8 ();

  iterative_divider #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  iterative_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division on integers, with the divide-by-zero convention.
  function automatic logic [127:0] ref_div(input int w, input logic [1:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb, q, r;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (op == 2'b10) begin
      sa = longint'(a << (64 - w)) >>> (64 - w);
      sb = longint'(b << (64 - w)) >>> (64 - w);
    end else begin
      sa = longint'(a & mask);
      sb = longint'(b & mask);
    end
    if (sb == 0) begin
      q = -1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return (128'(64'(q) & mask) << w) | 128'(64'(r) & mask);
  endfunction

  function automatic int zero_lat(input int w);
    return FastZero ? 2 : w + 2;
  endfunction

  task automatic drive(input int w, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b);
    if (w == 32) begin
      b32.div_op = op; b32.dividend = a[31:0]; b32.divisor = b[31:0];
    end else begin
      b8.div_op = op; b8.dividend = a[7:0]; b8.divisor = b[7:0];
    end
  endtask

  // Called just after a negedge; returns at the negedge where result_valid is seen.
  task automatic run_op(input int w, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [127:0] exp, input int exp_lat,
                        input bit noise, input string tag);
    int   lat, bhi;
    logic rv, bsy, dn;
    logic [127:0] res;
    drive(w, op, a, b);
    @(negedge clk);
    lat = 0;
    bhi = 0;
    rv  = (w == 32) ? b32.result_valid : b8.result_valid;
    while (!rv && lat < 200) begin
      bsy = (w == 32) ? b32.busy : b8.busy;
      if (bsy) bhi++;
      if (noise) drive(w, 2'($urandom), 64'($urandom), 64'($urandom));
      else drive(w, 2'b00, 64'd0, 64'd0);
      @(negedge clk);
      lat++;
      rv = (w == 32) ? b32.result_valid : b8.result_valid;
    end
    drive(w, 2'b00, 64'd0, 64'd0);
    bsy = (w == 32) ? b32.busy : b8.busy;
    dn  = (w == 32) ? b32.done : b8.done;
    res = (w == 32) ? 128'(b32.result) : 128'(b8.result);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, bhi, exp_lat);
    check({tag, ".result"}, res, exp);
    check({tag, ".busy_done_end"}, {bsy, dn}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int rv_count;
    rst = 1'b1;
    b32.flush = 1'b0;
    b8.flush  = 1'b0;
    drive(32, 2'b00, 64'd0, 64'd0);
    drive(8, 2'b00, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    check("rst32.result", b32.result, 64'd0);
    check("rst32.rv_busy_done", {b32.result_valid, b32.busy, b32.done}, 3'b001);
    check("rst8.result", b8.result, 16'd0);
    check("rst8.rv_busy_done", {b8.result_valid, b8.busy, b8.done}, 3'b001);
    rst = 1'b0;
    @(negedge clk);

    run_op(32, 2'b01, 64'd100, 64'd7, 64'h0000000E_00000002, 34, 1'b0, "u100div7");
    repeat (3) begin
      @(negedge clk);
      check("hold.result", b32.result, 64'h0000000E_00000002);
      check("hold.rv", b32.result_valid, 1'b0);
    end

    run_op(32, 2'b10, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD_FFFFFFFF, 34, 1'b0, "s_m7div2");
    run_op(32, 2'b10, 64'd7, 64'hFFFFFFFE, 64'hFFFFFFFD_00000001, 34, 1'b0, "s7div_m2");
    run_op(32, 2'b10, 64'h80000000, 64'hFFFFFFFF, 64'h80000000_00000000, 34, 1'b0, "s_ovf");
    run_op(32, 2'b01, 64'h80000000, 64'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0, "u_big");
    run_op(32, 2'b01, 64'hFFFFFFFF, 64'd2, 64'h7FFFFFFF_00000001, 34, 1'b0, "u_max_div2");
    run_op(32, 2'b10, 64'hFFFFFFFB, 64'd0, 64'hFFFFFFFF_FFFFFFFB, zero_lat(32), 1'b0,
           "s_div0");
    run_op(32, 2'b01, 64'd1234, 64'd0, 64'hFFFFFFFF_000004D2, zero_lat(32), 1'b0, "u_div0");
    run_op(32, 2'b01, 64'd1000, 64'd3, 64'h0000014D_00000001, 34, 1'b1, "busy_ignore");

    // Flush at E0+10, then a new op on the following edge
    drive(32, 2'b01, 64'd100, 64'd7);
    @(negedge clk);
    drive(32, 2'b00, 64'd0, 64'd0);
    repeat (9) @(negedge clk);
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0;
    check("flush.rv_busy_done", {b32.result_valid, b32.busy, b32.done}, 3'b001);
    check("flush.result_kept", b32.result, 64'h0000014D_00000001);
    run_op(32, 2'b01, 64'hFFFFFFFF, 64'd1, 64'hFFFFFFFF_00000000, 34, 1'b0, "after_flush");

    // Start together with flush in idle must be dropped
    drive(32, 2'b01, 64'd5, 64'd1);
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0;
    drive(32, 2'b00, 64'd0, 64'd0);
    check("flush_start.busy", b32.busy, 1'b0);
    rv_count = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.result_valid || b32.busy) rv_count++;
    end
    check("flush_start.no_activity", rv_count, 0);
    check("flush_start.result", b32.result, 64'hFFFFFFFF_00000000);

    // Reset at E0+5
    drive(32, 2'b01, 64'd100, 64'd7);
    @(negedge clk);
    drive(32, 2'b00, 64'd0, 64'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.result", b32.result, 64'd0);
    check("midrst.rv_busy_done", {b32.result_valid, b32.busy, b32.done}, 3'b001);
    rv_count = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.result_valid) rv_count++;
    end
    check("midrst.no_strobe", rv_count, 0);
    run_op(32, 2'b01, 64'd9, 64'd4, 64'h00000002_00000001, 34, 1'b0, "after_rst");

    run_op(8, 2'b01, 64'd255, 64'd16, 16'h0F0F, 10, 1'b0, "w8_u255div16");
    run_op(8, 2'b10, 64'h80, 64'hFF, 16'h8000, 10, 1'b0, "w8_s_ovf");
    run_op(8, 2'b10, 64'hF9, 64'h00, 16'hFFF9, zero_lat(8), 1'b0, "w8_s_div0");

    // Back-to-back random sweeps against the reference model
    for (int w = 8; w <= 32; w += 24) begin
      int n;
      n = (w == 8) ? 3000 : 300;
      for (int i = 0; i < n; i++) begin
        logic [1:0]   op;
        logic [63:0]  a, b, mask;
        logic [127:0] e;
        int           sel, l;
        mask = (64'd1 << w) - 64'd1;
        op   = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        a    = 64'($urandom) & mask;
        if ($urandom_range(0, 7) == 0) a = 64'd1 << (w - 1);
        sel = $urandom_range(0, 9);
        if (sel == 0) b = 64'd0;
        else if (sel == 1) b = mask;
        else if (sel == 2) b = 64'd1;
        else b = 64'($urandom) & mask;
        e = ref_div(w, op, a, b);
        l = (b == 64'd0) ? zero_lat(w) : w + 2;
        run_op(w, op, a, b, e, l, ($urandom_range(0, 3) == 0),
               (w == 8) ? "rnd8" : "rnd32");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
